// File: rtl/pipeline_ctrl.sv
`timescale 1ns/1ps
// pipeline_ctrl: hazard, freeze and halt sequencer for the 5-stage MIPS32
// pipeline. Drives every pipeline register's enable and synchronous flush,
// plus the E-stage ALU operand and D-stage branch-compare forwarding selects.
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             JumpD,
    input  logic             PCSrcD,
    input  logic             StopD,
    input  logic             MemReqM,
    input  logic             MemAckM,
    output logic             EnableF,
    output logic             EnableD,
    output logic             EnableE,
    output logic             EnableM,
    output logic             EnableW,
    output logic             RstD,
    output logic             RstE,
    output logic             RstM,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             Halted,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount
);

    localparam int TO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [TO_W-1:0]    TO_FIRST   = TO_W'(1);
    localparam logic [TO_W-1:0]    TO_ONE     = TO_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEMWAIT,
        ST_DRAIN,
        ST_HALT
    } state_t;

    state_t             state;
    state_t             resume_state;
    logic [TO_W-1:0]    wait_cnt;
    logic [DRAIN_W-1:0] drain_cnt;

    logic m_src_ok;
    logic w_src_ok;
    logic e_wr_ok;
    logic m_load_ok;
    logic e_hits_d;
    logic m_hits_d;
    logic lw_stall;
    logic br_stall;
    logic stall;
    logic redirect;
    logic mem_freeze;

    // Forwarding selects: M-stage result has priority over W; $0 is never forwarded.
    always_comb begin
        m_src_ok = RegWriteM && (WriteRegM != '0);
        w_src_ok = RegWriteW && (WriteRegW != '0);

        if (m_src_ok && (WriteRegM == RsE))
            ForwardAE = 2'b10;
        else if (w_src_ok && (WriteRegW == RsE))
            ForwardAE = 2'b01;
        else
            ForwardAE = 2'b00;

        if (m_src_ok && (WriteRegM == RtE))
            ForwardBE = 2'b10;
        else if (w_src_ok && (WriteRegW == RtE))
            ForwardBE = 2'b01;
        else
            ForwardBE = 2'b00;

        ForwardAD = m_src_ok && (WriteRegM == RsD);
        ForwardBD = m_src_ok && (WriteRegM == RtD);
    end

    // Hazard detection: load-use, and branch operands not yet available in D.
    always_comb begin
        e_wr_ok    = RegWriteE && (WriteRegE != '0);
        m_load_ok  = MemtoRegM && (WriteRegM != '0);
        e_hits_d   = (WriteRegE == RsD) || (WriteRegE == RtD);
        m_hits_d   = (WriteRegM == RsD) || (WriteRegM == RtD);
        lw_stall   = MemtoRegE && e_wr_ok && e_hits_d;
        br_stall   = BranchD && ((e_wr_ok && e_hits_d) || (m_load_ok && m_hits_d));
        stall      = lw_stall || br_stall;
        redirect   = PCSrcD || JumpD;
        mem_freeze = MemReqM && !MemAckM;
    end

    // Stage enables and flushes from current state and this cycle's hazards.
    always_comb begin
        EnableF = 1'b0;
        EnableD = 1'b0;
        EnableE = 1'b0;
        EnableM = 1'b0;
        EnableW = 1'b0;
        RstD    = 1'b0;
        RstE    = 1'b0;
        RstM    = 1'b0;

        if (!RSTn) begin
            RstD = 1'b1;
            RstE = 1'b1;
            RstM = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!mem_freeze) begin
                        EnableF = 1'b1;
                        EnableD = 1'b1;
                        EnableE = 1'b1;
                        EnableM = 1'b1;
                        EnableW = 1'b1;
                        if (stall) begin
                            EnableF = 1'b0;
                            EnableD = 1'b0;
                            RstE    = 1'b1;
                        end else if (redirect) begin
                            RstD = 1'b1;
                        end else if (StopD) begin
                            RstD    = 1'b1;
                            EnableF = 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!mem_freeze) begin
                        EnableD = 1'b1;
                        EnableE = 1'b1;
                        EnableM = 1'b1;
                        EnableW = 1'b1;
                        RstD    = 1'b1;
                    end
                end
                default: begin
                    // MEMWAIT and HALT hold every stage register.
                end
            endcase
        end
    end

    // Sequencer state, wait/drain counters and sticky status registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state        <= ST_RUN;
            resume_state <= ST_RUN;
            wait_cnt     <= '0;
            drain_cnt    <= '0;
            Halted       <= 1'b0;
            MemErr       <= 1'b0;
            StallCount   <= '0;
        end else begin
            if ((state != ST_HALT) && !EnableD && (StallCount != '1))
                StallCount <= StallCount + CNT_ONE;

            case (state)
                ST_RUN: begin
                    if (mem_freeze) begin
                        state        <= ST_MEMWAIT;
                        resume_state <= ST_RUN;
                        wait_cnt     <= TO_FIRST;
                    end else if (!stall && !redirect && StopD) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_INIT;
                    end
                end
                ST_MEMWAIT: begin
                    if (MemAckM) begin
                        state <= resume_state;
                    end else if (wait_cnt == TO_LAST) begin
                        wait_cnt <= wait_cnt + TO_ONE;
                        MemErr   <= 1'b1;
                        Halted   <= 1'b1;
                        state    <= ST_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + TO_ONE;
                    end
                end
                ST_DRAIN: begin
                    // A freeze parks the drain count; it resumes on return from MEMWAIT.
                    if (mem_freeze) begin
                        state        <= ST_MEMWAIT;
                        resume_state <= ST_DRAIN;
                        wait_cnt     <= TO_FIRST;
                    end else if (drain_cnt <= DRAIN_ONE) begin
                        drain_cnt <= '0;
                        Halted    <= 1'b1;
                        state     <= ST_HALT;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_ONE;
                    end
                end
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
`timescale 1ns/1ps
// tb_pipeline_ctrl: scoreboard bench. A stimulus process drives each cycle's
// inputs and pushes the reference model's expected outputs; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_pipeline_ctrl;

    localparam int DRAIN_CYCLES = 4;
    localparam int MEM_TIMEOUT  = 15;
    localparam int CNT_W        = 4;
    localparam int unsigned STALL_MAX = (1 << CNT_W) - 1;

    logic CLK = 1'b0;
    logic RSTn;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic BranchD, JumpD, PCSrcD, StopD, MemReqM, MemAckM;
    logic EnableF, EnableD, EnableE, EnableM, EnableW;
    logic RstD, RstE, RstM, ForwardAD, ForwardBD;
    logic [1:0] ForwardAE, ForwardBE;
    logic Halted, MemErr;
    logic [CNT_W-1:0] StallCount;

    pipeline_ctrl #(
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK(CLK), .RSTn(RSTn),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .JumpD(JumpD), .PCSrcD(PCSrcD), .StopD(StopD),
        .MemReqM(MemReqM), .MemAckM(MemAckM),
        .EnableF(EnableF), .EnableD(EnableD), .EnableE(EnableE),
        .EnableM(EnableM), .EnableW(EnableW),
        .RstD(RstD), .RstE(RstE), .RstM(RstM),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .Halted(Halted), .MemErr(MemErr), .StallCount(StallCount)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  en;     // {F,D,E,M,W}
        logic [2:0]  rst;    // {D,E,M}
        logic [1:0]  fae;
        logic [1:0]  fbe;
        logic        fad;
        logic        fbd;
        logic        halted;
        logic        err;
        int unsigned stalls;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;

    // Reference model state, in terms of what the machine is doing rather than how.
    bit          m_halted, m_err, m_waiting, m_draining;
    int unsigned m_wait_len, m_drain_left, m_stalls;

    function automatic logic [1:0] fwd_e(input logic [4:0] r);
        if (r == 5'd0) return 2'b00;
        if (RegWriteM && WriteRegM == r) return 2'b10;
        if (RegWriteW && WriteRegW == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic fwd_d(input logic [4:0] r);
        return (r != 5'd0) && RegWriteM && (WriteRegM == r);
    endfunction

    // Does the instruction in D read register d (nonzero)?
    function automatic bit d_reads(input logic [4:0] d);
        return (d != 5'd0) && (d == RsD || d == RtD);
    endfunction

    task automatic model_push();
        exp_t e;
        bit halted_before;
        bit hazard;
        logic [4:0] load_in_e, write_in_e, load_in_m;
        e.cyc = cyc;
        e.fae = fwd_e(RsE);
        e.fbe = fwd_e(RtE);
        e.fad = fwd_d(RsD);
        e.fbd = fwd_d(RtD);
        if (!RSTn) begin
            m_halted = 0; m_err = 0; m_waiting = 0; m_draining = 0;
            m_wait_len = 0; m_drain_left = 0; m_stalls = 0;
            e.en = 5'b00000; e.rst = 3'b111;
            e.halted = 0; e.err = 0; e.stalls = 0;
            sb.push_back(e);
            return;
        end
        e.halted = m_halted;
        e.err    = m_err;
        e.stalls = m_stalls;
        e.en     = 5'b00000;
        e.rst    = 3'b000;
        halted_before = m_halted;
        load_in_e  = (MemtoRegE && RegWriteE) ? WriteRegE : 5'd0;
        write_in_e = RegWriteE ? WriteRegE : 5'd0;
        load_in_m  = MemtoRegM ? WriteRegM : 5'd0;
        hazard = d_reads(load_in_e) ||
                 (BranchD && (d_reads(write_in_e) || d_reads(load_in_m)));
        if (m_halted) begin
            // frozen for good
        end else if (m_waiting) begin
            if (MemAckM) m_waiting = 0;
            else begin
                m_wait_len++;
                if (m_wait_len >= MEM_TIMEOUT) begin
                    m_err = 1; m_halted = 1; m_waiting = 0; m_draining = 0;
                end
            end
        end else if (MemReqM && !MemAckM) begin
            m_waiting = 1; m_wait_len = 1;
        end else if (m_draining) begin
            e.en = 5'b01111; e.rst = 3'b100;
            m_drain_left--;
            if (m_drain_left == 0) begin m_draining = 0; m_halted = 1; end
        end else begin
            e.en = 5'b11111;
            if (hazard) begin
                e.en = 5'b00111; e.rst = 3'b010;
            end else if (PCSrcD || JumpD) begin
                e.rst = 3'b100;
            end else if (StopD) begin
                e.en = 5'b01111; e.rst = 3'b100;
                m_draining = 1; m_drain_left = DRAIN_CYCLES;
            end
        end
        if (!halted_before && !e.en[3])
            m_stalls = (m_stalls < STALL_MAX) ? m_stalls + 1 : STALL_MAX;
        sb.push_back(e);
    endtask

    task automatic clear_inputs();
        RsD = '0; RtD = '0; RsE = '0; RtE = '0;
        WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0;
        BranchD = 0; JumpD = 0; PCSrcD = 0; StopD = 0;
        MemReqM = 0; MemAckM = 0;
    endtask

    // Inputs are already set (posedge+1); record expectation, advance one cycle.
    task automatic step();
        model_push();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int unsigned n);
        RSTn = 0;
        for (int unsigned i = 0; i < n; i++) step();
        RSTn = 1;
    endtask

    task automatic random_inputs();
        RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
        RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
        WriteRegE = 5'($urandom_range(0, 3));
        WriteRegM = 5'($urandom_range(0, 3));
        WriteRegW = 5'($urandom_range(0, 3));
        RegWriteE = 1'($urandom_range(0, 1));
        RegWriteM = 1'($urandom_range(0, 1));
        RegWriteW = 1'($urandom_range(0, 1));
        MemtoRegE = ($urandom_range(0, 2) == 0);
        MemtoRegM = ($urandom_range(0, 2) == 0);
        BranchD   = ($urandom_range(0, 3) == 0);
        PCSrcD    = BranchD && ($urandom_range(0, 1) == 1);
        JumpD     = ($urandom_range(0, 9) == 0);
        StopD     = ($urandom_range(0, 24) == 0);
        MemReqM   = ($urandom_range(0, 4) == 0);
        MemAckM   = m_waiting ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
    endtask

    task automatic chk(input string name, input int unsigned c,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, got, exp);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("enables",  e.cyc, 32'({EnableF, EnableD, EnableE, EnableM, EnableW}), 32'(e.en));
            chk("flushes",  e.cyc, 32'({RstD, RstE, RstM}), 32'(e.rst));
            chk("fwd_e",    e.cyc, 32'({ForwardAE, ForwardBE}), 32'({e.fae, e.fbe}));
            chk("fwd_d",    e.cyc, 32'({ForwardAD, ForwardBD}), 32'({e.fad, e.fbd}));
            chk("status",   e.cyc, 32'({Halted, MemErr}), 32'({e.halted, e.err}));
            chk("stallcnt", e.cyc, 32'(StallCount), e.stalls);
        end
    end

    initial begin
        int unsigned halt_run;
        clear_inputs();
        RSTn = 0;
        @(posedge CLK);
        #1;
        do_reset(2);

        // Load-use on $3, then the load moves to M and W.
        RegWriteE = 1; MemtoRegE = 1; WriteRegE = 5'd3; RsD = 5'd3;
        step();
        clear_inputs();
        RegWriteM = 1; MemtoRegM = 1; WriteRegM = 5'd3; RsE = 5'd3;
        step();
        clear_inputs();
        RegWriteW = 1; WriteRegW = 5'd3; RsE = 5'd3;
        step();

        // Forwarding priority and $0 exclusion.
        clear_inputs();
        RegWriteM = 1; WriteRegM = 5'd5; RegWriteW = 1; WriteRegW = 5'd5;
        RsE = 5'd5; RtE = 5'd5; RsD = 5'd5;
        step();
        WriteRegM = 5'd0; WriteRegW = 5'd0; RsE = 5'd0; RtE = 5'd0; RsD = 5'd0;
        step();

        // Taken branch flush, then the same with a load-use hazard.
        clear_inputs();
        BranchD = 1; PCSrcD = 1;
        step();
        RegWriteE = 1; MemtoRegE = 1; WriteRegE = 5'd7; RtD = 5'd7;
        step();
        clear_inputs();
        JumpD = 1;
        step();

        // Short memory wait, then a full timeout into HALT.
        clear_inputs();
        MemReqM = 1;
        for (int i = 0; i < 3; i++) step();
        MemAckM = 1;
        step();
        clear_inputs();
        step();
        MemReqM = 1;
        for (int i = 0; i < 15; i++) step();
        clear_inputs();
        for (int i = 0; i < 3; i++) step();
        do_reset(1);

        // Stop, drain with one memory freeze, then halted.
        clear_inputs();
        StopD = 1;
        step();
        clear_inputs();
        step();
        step();
        MemReqM = 1;
        step();
        MemAckM = 1;
        step();
        clear_inputs();
        for (int i = 0; i < 5; i++) step();
        do_reset(1);

        // Reset arriving in the middle of a drain.
        clear_inputs();
        RegWriteE = 1; MemtoRegE = 1; WriteRegE = 5'd2; RsD = 5'd2;
        step();
        step();
        clear_inputs();
        StopD = 1;
        step();
        clear_inputs();
        step();
        step();
        do_reset(2);
        step();
        step();

        // Stall counter saturation.
        RegWriteE = 1; MemtoRegE = 1; WriteRegE = 5'd1; RsD = 5'd1;
        for (int i = 0; i < 20; i++) step();
        clear_inputs();
        step();
        do_reset(1);

        // Randomized traffic with periodic recovery from HALT.
        halt_run = 0;
        for (int i = 0; i < 4000; i++) begin
            random_inputs();
            if (m_halted) halt_run++;
            else halt_run = 0;
            RSTn = !((halt_run > 3) || ($urandom_range(0, 199) == 0));
            if (!RSTn) halt_run = 0;
            step();
        end
        RSTn = 1;
        clear_inputs();

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_scoreboard pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
